wash_plant_model: RTL and testbench

//  Actuator-side counterpart of the washing controller's ctrl_* command interface.
//  - Consumes ctrl_fill, ctrl_release, ctrl_forward and ctrl_reverse.
//  - Models the tank water level and the drum motor.
//  - Enforces actuator safety rules and latches the first violation as a sticky fault.
//  - Used in benches and on the FPGA demo board, in place of the real valves and motor.

---
 rtl/wash_plant_model.sv | 179 +++++++++++++++++
 tb/tb_wash_plant_model.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/wash_plant_model.sv
// -----------------------------------------------------------------------------
// wash_plant_model
//   Actuator-side model of the washing machine plant. It takes the controller's
//   valve and motor commands, models the tank water level and the drum motor
//   direction/dead-time, and latches the first actuator safety violation as a
//   sticky fault while counting every violation cycle.
//
// Ports
//   clk           in   1        system clock
//   rst_n         in   1        synchronous active-low reset
//   ctrl_fill     in   1        inlet valve command
//   ctrl_release  in   1        drain valve command
//   ctrl_forward  in   1        motor forward command
//   ctrl_reverse  in   1        motor reverse command
//   fault_clr     in   1        single-cycle pulse clearing the sticky fault
//   level         out  LEVEL_W  modelled water level
//   level_full    out  1        level == LEVEL_MAX
//   level_empty   out  1        level == 0
//   motor_state   out  2        0=IDLE 1=FWD 2=REV 3=DEAD
//   fault         out  1        sticky fault flag
//   fault_code    out  2        0=none 1=FILL_DRAIN 2=DIR_CONFLICT 3=DEADTIME
//   fault_cnt     out  8        violation-cycle count, saturating at 255
// -----------------------------------------------------------------------------
module wash_plant_model #(
   parameter int LEVEL_W    = 8,
   parameter int LEVEL_MAX  = 64,
   parameter int FILL_RATE  = 1,
   parameter int DRAIN_RATE = 2,
   parameter int DEADTIME   = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ctrl_fill,
   input  logic               ctrl_release,
   input  logic               ctrl_forward,
   input  logic               ctrl_reverse,
   input  logic               fault_clr,
   output logic [LEVEL_W-1:0] level,
   output logic               level_full,
   output logic               level_empty,
   output logic [1:0]         motor_state,
   output logic               fault,
   output logic [1:0]         fault_code,
   output logic [7:0]         fault_cnt
);

   localparam int DEAD_W = $clog2(DEADTIME + 1);

   localparam logic [LEVEL_W-1:0] LVL_MAX   = LEVEL_W'(LEVEL_MAX);
   localparam logic [LEVEL_W-1:0] LVL_FILL  = LEVEL_W'(FILL_RATE);
   localparam logic [LEVEL_W-1:0] LVL_DRAIN = LEVEL_W'(DRAIN_RATE);
   localparam logic [DEAD_W-1:0]  DEAD_LOAD = DEAD_W'(DEADTIME);

   typedef enum logic [1:0] {
      M_IDLE = 2'd0,
      M_FWD  = 2'd1,
      M_REV  = 2'd2,
      M_DEAD = 2'd3
   } motor_e;

   typedef enum logic [1:0] {
      F_NONE         = 2'd0,
      F_FILL_DRAIN   = 2'd1,
      F_DIR_CONFLICT = 2'd2,
      F_DEADTIME     = 2'd3
   } fault_e;

   logic [LEVEL_W-1:0] level_q, level_d;
   motor_e             motor_q, motor_d;
   logic [DEAD_W-1:0]  dead_q, dead_d;
   logic               fault_q, fault_d;
   fault_e             code_q, code_d;
   logic [7:0]         cnt_q, cnt_d;

   logic   fd_viol, dir_viol, dt_viol, any_viol;
   fault_e new_code;

   // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      level_d  = level_q;
      motor_d  = motor_q;
      dead_d   = dead_q;
      fault_d  = fault_q;
      code_d   = code_q;
      cnt_d    = cnt_q;
      dt_viol  = 1'b0;
      new_code = F_NONE;

      // Level: saturating fill/drain; opening both valves holds the level.
      fd_viol = ctrl_fill & ctrl_release;
      if (ctrl_fill && !ctrl_release) begin
         if (int'(level_q) + FILL_RATE >= LEVEL_MAX) level_d = LVL_MAX;
         else                                        level_d = level_q + LVL_FILL;
      end else if (ctrl_release && !ctrl_fill) begin
         if (int'(level_q) <= DRAIN_RATE) level_d = '0;
         else                             level_d = level_q - LVL_DRAIN;
      end

      // Motor: any exit from a driven state passes through DEAD with a fresh count.
      dir_viol = ctrl_forward & ctrl_reverse;
      unique case (motor_q)
         M_IDLE: begin
            if (ctrl_forward && !ctrl_reverse)      motor_d = M_FWD;
            else if (ctrl_reverse && !ctrl_forward) motor_d = M_REV;
         end
         M_FWD: begin
            if (!(ctrl_forward && !ctrl_reverse)) begin
               motor_d = M_DEAD;
               dead_d  = DEAD_LOAD;
               dt_viol = ctrl_reverse & ~ctrl_forward;  // direct reversal
            end
         end
         M_REV: begin
            if (!(ctrl_reverse && !ctrl_forward)) begin
               motor_d = M_DEAD;
               dead_d  = DEAD_LOAD;
               dt_viol = ctrl_forward & ~ctrl_reverse;  // direct reversal
            end
         end
         M_DEAD: begin
            // Commands are ignored here; the dead time runs to completion regardless.
            dt_viol = ctrl_forward | ctrl_reverse;
            if (dead_q <= DEAD_W'(1)) begin
               motor_d = M_IDLE;
               dead_d  = '0;
            end else begin
               dead_d  = dead_q - DEAD_W'(1);
            end
         end
         default: motor_d = M_IDLE;
      endcase

      // Faults: priority FILL_DRAIN > DIR_CONFLICT > DEADTIME.
      any_viol = fd_viol | dir_viol | dt_viol;
      if (fd_viol)       new_code = F_FILL_DRAIN;
      else if (dir_viol) new_code = F_DIR_CONFLICT;
      else if (dt_viol)  new_code = F_DEADTIME;

      if (any_viol) begin
         // A clear coinciding with a new violation re-arms with the new code.
         if (!fault_q || fault_clr) begin
            fault_d = 1'b1;
            code_d  = new_code;
         end
         if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
      end else if (fault_clr) begin
         fault_d = 1'b0;
         code_d  = F_NONE;
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together from pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         level_q <= '0;
         motor_q <= M_IDLE;
         dead_q  <= '0;
         fault_q <= 1'b0;
         code_q  <= F_NONE;
         cnt_q   <= '0;
      end else begin
         level_q <= level_d;
         motor_q <= motor_d;
         dead_q  <= dead_d;
         fault_q <= fault_d;
         code_q  <= code_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level       = level_q;
   assign level_full  = (level_q == LVL_MAX);
   assign level_empty = (level_q == '0);
   assign motor_state = motor_q;
   assign fault       = fault_q;
   assign fault_code  = code_q;
   assign fault_cnt   = cnt_q;

endmodule

// File: tb/tb_wash_plant_model.sv
// -----------------------------------------------------------------------------
// tb_wash_plant_model
//   Directed bench for wash_plant_model. Each stimulus cycle pushes the outputs
//   expected after the next clock edge into a scoreboard queue; an independent
//   monitor pops one entry per edge and compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_wash_plant_model;

   typedef struct packed {
      logic [7:0] level;
      logic       full;
      logic       empty;
      logic [1:0] motor;
      logic       fault;
      logic [1:0] code;
      logic [7:0] cnt;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ctrl_fill, ctrl_release, ctrl_forward, ctrl_reverse, fault_clr;
   logic [7:0] level;
   logic       level_full, level_empty;
   logic [1:0] motor_state;
   logic       fault;
   logic [1:0] fault_code;
   logic [7:0] fault_cnt;

   exp_t  sb_q[$];
   string name_q[$];
   int    n_tests = 0;
   int    n_fail  = 0;

   // Expected post-edge values, set by the stimulus before each cycle.
   logic [7:0] e_level;
   logic [1:0] e_motor;
   logic       e_fault;
   logic [1:0] e_code;
   logic [7:0] e_cnt;

   always #5 clk = ~clk;

   wash_plant_model dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ctrl_fill    (ctrl_fill),
      .ctrl_release (ctrl_release),
      .ctrl_forward (ctrl_forward),
      .ctrl_reverse (ctrl_reverse),
      .fault_clr    (fault_clr),
      .level        (level),
      .level_full   (level_full),
      .level_empty  (level_empty),
      .motor_state  (motor_state),
      .fault        (fault),
      .fault_code   (fault_code),
      .fault_cnt    (fault_cnt)
   );

   // Drive one cycle of inputs (at the falling edge) and queue the expected result.
   task automatic cyc(input string name, input bit rst_v, fill_v, rel_v, fwd_v, rev_v, clr_v);
      exp_t e;
      rst_n        = rst_v;
      ctrl_fill    = fill_v;
      ctrl_release = rel_v;
      ctrl_forward = fwd_v;
      ctrl_reverse = rev_v;
      fault_clr    = clr_v;
      e.level = e_level;
      e.full  = (e_level == 8'd64);
      e.empty = (e_level == 8'd0);
      e.motor = e_motor;
      e.fault = e_fault;
      e.code  = e_code;
      e.cnt   = e_cnt;
      sb_q.push_back(e);
      name_q.push_back(name);
      @(negedge clk);
   endtask

   task automatic clear_exp();
      e_level = 8'd0;
      e_motor = 2'd0;
      e_fault = 1'b0;
      e_code  = 2'd0;
      e_cnt   = 8'd0;
   endtask

   // Monitor: one comparison per clock edge while expectations are pending.
   initial begin
      exp_t  e, a;
      string nm;
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            e  = sb_q.pop_front();
            nm = name_q.pop_front();
            a.level = level;
            a.full  = level_full;
            a.empty = level_empty;
            a.motor = motor_state;
            a.fault = fault;
            a.code  = fault_code;
            a.cnt   = fault_cnt;
            n_tests++;
            if (a !== e) begin
               n_fail++;
               $display("FAIL %s @%0t: got lvl=%0d full=%0b empty=%0b motor=%0d fault=%0b code=%0d cnt=%0d, want lvl=%0d full=%0b empty=%0b motor=%0d fault=%0b code=%0d cnt=%0d",
                        nm, $time, a.level, a.full, a.empty, a.motor, a.fault, a.code, a.cnt,
                        e.level, e.full, e.empty, e.motor, e.fault, e.code, e.cnt);
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0; ctrl_fill = 1'b0; ctrl_release = 1'b0;
      ctrl_forward = 1'b0; ctrl_reverse = 1'b0; fault_clr = 1'b0;
      clear_exp();
      @(negedge clk);

      // Reset state.
      cyc("reset", 0, 0, 0, 0, 0, 0);

      // T1: fill for 70 cycles; level saturates at 64.
      for (int i = 1; i <= 70; i++) begin
         e_level = 8'((i >= 64) ? 64 : i);
         cyc("T1_fill", 1, 1, 0, 0, 0, 0);
      end

      // T2: drain for 40 cycles; level reaches 0 after 32 and holds.
      for (int i = 1; i <= 40; i++) begin
         e_level = 8'((64 - 2 * i <= 0) ? 0 : 64 - 2 * i);
         cyc("T2_drain", 1, 0, 1, 0, 0, 0);
      end

      // T3: forward, then one cycle to leave FWD plus four dead cycles, then reverse.
      e_motor = 2'd1;
      repeat (10) cyc("T3_fwd", 1, 0, 0, 1, 0, 0);
      e_motor = 2'd3;
      repeat (4) cyc("T3_dead", 1, 0, 0, 0, 0, 0);
      e_motor = 2'd0;
      cyc("T3_idle", 1, 0, 0, 0, 0, 0);
      e_motor = 2'd2;
      repeat (3) cyc("T3_rev", 1, 0, 0, 0, 1, 0);
      e_motor = 2'd3;
      repeat (4) cyc("T3_dead2", 1, 0, 0, 0, 0, 0);
      e_motor = 2'd0;
      cyc("T3_idle2", 1, 0, 0, 0, 0, 0);

      // T4: direct reversal FWD -> reverse.
      e_motor = 2'd1;
      cyc("T4_fwd", 1, 0, 0, 1, 0, 0);
      e_motor = 2'd3; e_fault = 1'b1; e_code = 2'd3; e_cnt = 8'd1;
      cyc("T4_reversal", 1, 0, 0, 0, 1, 0);
      repeat (3) cyc("T4_dead", 1, 0, 0, 0, 0, 0);
      e_motor = 2'd0;
      cyc("T4_idle", 1, 0, 0, 0, 0, 0);

      // T5: fill/drain conflict at level 20, clear, then clear racing a DIR_CONFLICT.
      clear_exp();
      cyc("T5_reset", 0, 0, 0, 0, 0, 0);
      for (int i = 1; i <= 20; i++) begin
         e_level = 8'(i);
         cyc("T5_fill", 1, 1, 0, 0, 0, 0);
      end
      e_fault = 1'b1; e_code = 2'd1;
      for (int i = 1; i <= 3; i++) begin
         e_cnt = 8'(i);
         cyc("T5_fill_drain", 1, 1, 1, 0, 0, 0);
      end
      e_fault = 1'b0; e_code = 2'd0;
      cyc("T5_clr", 1, 0, 0, 0, 0, 1);
      e_motor = 2'd1;
      cyc("T5_fwd", 1, 0, 0, 1, 0, 0);
      e_motor = 2'd3; e_fault = 1'b1; e_code = 2'd2; e_cnt = 8'd4;
      cyc("T5_clr_vs_conflict", 1, 0, 0, 1, 1, 1);
      repeat (3) cyc("T5_dead", 1, 0, 0, 0, 0, 0);
      e_motor = 2'd0;
      cyc("T5_idle", 1, 0, 0, 0, 0, 0);

      // T6: reset mid-operation overrides asserted commands.
      e_motor = 2'd1;
      for (int i = 1; i <= 10; i++) begin
         e_level = 8'(20 + i);
         cyc("T6_run", 1, 1, 0, 1, 0, 0);
      end
      clear_exp();
      cyc("T6_reset", 0, 1, 0, 1, 0, 0);
      cyc("T6_after", 1, 0, 0, 0, 0, 0);

      // Command during DEAD: violation raised, state stays DEAD, counter keeps running.
      e_motor = 2'd1;
      cyc("DT_fwd", 1, 0, 0, 1, 0, 0);
      e_motor = 2'd3;
      cyc("DT_dead1", 1, 0, 0, 0, 0, 0);
      e_fault = 1'b1; e_code = 2'd3; e_cnt = 8'd1;
      cyc("DT_cmd_in_dead", 1, 0, 0, 1, 0, 0);
      repeat (2) cyc("DT_dead", 1, 0, 0, 0, 0, 0);
      e_motor = 2'd0;
      cyc("DT_idle", 1, 0, 0, 0, 0, 0);

      // fault_cnt saturates at 255; only reset clears it.
      clear_exp();
      cyc("SAT_reset", 0, 0, 0, 0, 0, 0);
      e_fault = 1'b1; e_code = 2'd1;
      for (int i = 1; i <= 260; i++) begin
         e_cnt = 8'((i > 255) ? 255 : i);
         cyc("SAT_cnt", 1, 1, 1, 0, 0, 0);
      end
      e_fault = 1'b0; e_code = 2'd0;
      cyc("SAT_clr_keeps_cnt", 1, 0, 1, 0, 0, 1);

      // Drain the scoreboard with a bounded wait.
      for (int k = 0; k < 10 && sb_q.size() != 0; k++) @(posedge clk);
      #2;
      if (sb_q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
